// File: rtl/selen_mem_pkg.sv
// Shared types and constants for the memory-access stage.
package selen_mem_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} memState_t;

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam logic [3:0] WORD_BE = 4'b1111;
endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store data replication, byte enables, and
// load-lane extraction with sign extension.
module mem_lsu_align
  import selen_mem_pkg::*;
(
  input  logic              byteAcc,
  input  logic [1:0]        addrLo,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] loadData
);

  function automatic logic signed [DATA_W-1:0] sextLane(input logic signed [LANE_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    r = b;
    return r;
  endfunction

  logic [DATA_W-1:0] rdataShifted;
  logic signed [LANE_W-1:0] laneByte;

  always_comb begin
    rdataShifted = rdata >> {addrLo, 3'b000};
    laneByte     = rdataShifted[LANE_W-1:0];
    be           = byteAcc ? (4'b0001 << addrLo) : WORD_BE;
    wdata        = byteAcc ? {4{storeData[LANE_W-1:0]}} : storeData;
    loadData     = byteAcc ? sextLane(laneByte) : rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack load/store FSM with timeout, upstream stall,
// and MEM/WB registers. Optional misaligned-word check under MEM_MISALIGN_CHK_EN.
module mem_stage
  import selen_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int TMO_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] resultM,
  input  logic [31:0] srcbM,
  input  logic [31:0] addrM,
  input  logic [4:0]  rdM,
  input  logic        be_memM,
  input  logic        we_memM,
  input  logic        mux10M,
  input  logic        we_regM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic [31:0] resultW,
  output logic [4:0]  rdW,
  output logic        we_regW,
  output logic        bus_err
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  memState_t         state, stateNxt;
  logic [TMO_W-1:0]  tmoCnt;
  logic              memOp, isLoad, misalignHit, startOp, tmoHit;
  logic [DATA_W-1:0] alignWdata, loadData;
  logic [3:0]        alignBe;

  mem_lsu_align uAlign (
    .byteAcc   (be_memM),
    .addrLo    (addrM[1:0]),
    .storeData (srcbM),
    .rdata     (dmem_rdata),
    .wdata     (alignWdata),
    .be        (alignBe),
    .loadData  (loadData)
  );

  // A store wins when both store and load flags are raised.
  assign memOp  = we_memM | mux10M;
  assign isLoad = mux10M & ~we_memM;

`ifdef MEM_MISALIGN_CHK_EN
  assign misalignHit = memOp & ~be_memM & (addrM[1:0] != 2'b00);
  assign misalign    = (state == IDLE) & misalignHit;
`else
  assign misalignHit = 1'b0;
`endif

  assign startOp = (state == IDLE) & memOp & ~misalignHit;
  assign tmoHit  = (state == BUSY) & ~dmem_ack & (tmoCnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    stallM   = 1'b0;
    case (state)
      IDLE: begin
        if (startOp) begin
          stateNxt = BUSY;
          stallM   = 1'b1;
        end
      end
      BUSY: begin
        if (dmem_ack || tmoHit) stateNxt = IDLE;
        else                    stallM   = 1'b1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Bus request, timeout counter and MEM/WB boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmoCnt     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      resultW    <= '0;
      rdW        <= '0;
      we_regW    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= tmoHit;
      case (state)
        IDLE: begin
          tmoCnt <= '0;
          if (startOp) begin
            dmem_req   <= 1'b1;
            dmem_we    <= we_memM;
            dmem_addr  <= {addrM[31:2], 2'b00};
            dmem_wdata <= alignWdata;
            dmem_be    <= alignBe;
            we_regW    <= 1'b0;
          end else if (misalignHit) begin
            we_regW <= 1'b0;
          end else begin
            resultW <= resultM;
            rdW     <= rdM;
            we_regW <= we_regM;
          end
        end
        BUSY: begin
          tmoCnt <= tmoCnt + 1'b1;
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            rdW      <= rdM;
            we_regW  <= isLoad & we_regM;
            if (isLoad) resultW <= loadData;
          end else if (tmoHit) begin
            dmem_req <= 1'b0;
            we_regW  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: reset, table vectors, timeout, reset
// abort, misalign/forced alignment, and randomized ops against a byte memory model.
module tb_mem_stage;
  logic        clk, rst;
  logic [31:0] resultM, srcbM, addrM, dmem_addr, dmem_wdata, dmem_rdata, resultW;
  logic [4:0]  rdM, rdW;
  logic        be_memM, we_memM, mux10M, we_regM;
  logic        dmem_req, dmem_we, dmem_ack, stallM, we_regW, bus_err;
  logic [3:0]  dmem_be;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int nCmp = 0;
  int nFail = 0;
  logic [7:0] memB [64];

  mem_stage #(.TIMEOUT_CYC(16), .TMO_W(5)) dut (
    .clk(clk), .rst(rst), .resultM(resultM), .srcbM(srcbM), .addrM(addrM), .rdM(rdM),
    .be_memM(be_memM), .we_memM(we_memM), .mux10M(mux10M), .we_regM(we_regM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stallM(stallM),
    .resultW(resultW), .rdW(rdW), .we_regW(we_regW), .bus_err(bus_err)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign(misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr, srcb, rdata;
    logic        be, we, ld;
    int          dly;
    logic [3:0]  eBe;
    logic [31:0] eAddr, eWd, eRes;
    logic        eWe;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic setNop();
    resultM = '0; srcbM = '0; addrM = '0; rdM = '0;
    be_memM = 1'b0; we_memM = 1'b0; mux10M = 1'b0; we_regM = 1'b0;
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic doOp(input string nm, input logic [31:0] res, input logic [31:0] srcb,
                      input logic [31:0] addr, input logic [4:0] rd, input logic be,
                      input logic we, input logic ld, input logic wer, input int dly,
                      input logic [31:0] rdata, input logic [31:0] eAddr, input logic [3:0] eBe,
                      input logic [31:0] eWd, input logic [31:0] eRes, input logic eWe);
    resultM = res; srcbM = srcb; addrM = addr; rdM = rd;
    be_memM = be; we_memM = we; mux10M = ld; we_regM = wer;
    dmem_ack = 1'b0;
    #1;
    if (!(we | ld)) begin
      chk({nm, ".stall"}, 32'(stallM), 32'd0);
      @(posedge clk); #1;
      chk({nm, ".weW"}, 32'(we_regW), 32'(eWe));
      chk({nm, ".resW"}, resultW, eRes);
      chk({nm, ".rdW"}, 32'(rdW), 32'(rd));
    end else begin
      chk({nm, ".stallIdle"}, 32'(stallM), 32'd1);
      @(posedge clk); #1;
      chk({nm, ".req"}, 32'(dmem_req), 32'd1);
      chk({nm, ".addr"}, dmem_addr, eAddr);
      chk({nm, ".be"}, 32'(dmem_be), 32'(eBe));
      chk({nm, ".we"}, 32'(dmem_we), 32'(we));
      if (we) chk({nm, ".wdata"}, dmem_wdata, eWd);
      chk({nm, ".bubble"}, 32'(we_regW), 32'd0);
      for (int i = 0; i < dly; i++) begin
        chk({nm, ".stallBusy"}, 32'(stallM), 32'd1);
        @(posedge clk); #1;
        chk({nm, ".reqHold"}, 32'(dmem_req), 32'd1);
      end
      dmem_ack = 1'b1; dmem_rdata = rdata;
      #1;
      chk({nm, ".stallAck"}, 32'(stallM), 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk({nm, ".weW"}, 32'(we_regW), 32'(eWe));
      if (eWe) begin
        chk({nm, ".resW"}, resultW, eRes);
        chk({nm, ".rdW"}, 32'(rdW), 32'(rd));
      end
      chk({nm, ".reqDrop"}, 32'(dmem_req), 32'd0);
    end
  endtask

  function automatic logic [31:0] memWord(input int a);
    int al = a & ~3;
    return {memB[al+3], memB[al+2], memB[al+1], memB[al]};
  endfunction

  initial begin
    setNop();
    dmem_ack = 1'b0; dmem_rdata = '0;
    rst = 1'b1;
    #12;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.resW", resultW, 32'd0);
    chk("rst.rdW", 32'(rdW), 32'd0);
    chk("rst.weW", 32'(we_regW), 32'd0);
    chk("rst.busErr", 32'(bus_err), 32'd0);
    chk("rst.stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    doOp("alu", 32'h1234, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0,
         32'h0, 4'h0, 32'h0, 32'h1234, 1'b1);

    tbl[0] = '{32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 2, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1};
    tbl[1] = '{32'h203, 32'hAB, 32'h0, 1'b1, 1'b1, 1'b0, 0, 4'h8, 32'h200, 32'hABABABAB, 32'h0, 1'b0};
    tbl[2] = '{32'h101, 32'h0, 32'h00008000, 1'b1, 1'b0, 1'b1, 1, 4'h2, 32'h100, 32'h0, 32'hFFFFFF80, 1'b1};
    tbl[3] = '{32'h101, 32'h0, 32'h00007F00, 1'b1, 1'b0, 1'b1, 0, 4'h2, 32'h100, 32'h0, 32'h0000007F, 1'b1};
    tbl[4] = '{32'h102, 32'h0, 32'h00800000, 1'b1, 1'b0, 1'b1, 3, 4'h4, 32'h100, 32'h0, 32'hFFFFFF80, 1'b1};
    tbl[5] = '{32'h100, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b1, 0, 4'h1, 32'h100, 32'h0, 32'h00000078, 1'b1};
    tbl[6] = '{32'h10F, 32'h0, 32'h81000000, 1'b1, 1'b0, 1'b1, 1, 4'h8, 32'h10C, 32'h0, 32'hFFFFFF81, 1'b1};
    tbl[7] = '{32'h104, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b0, 1, 4'hF, 32'h104, 32'hCAFEF00D, 32'h0, 1'b0};
    tbl[8] = '{32'h010, 32'h12345655, 32'h0, 1'b1, 1'b1, 1'b1, 0, 4'h1, 32'h010, 32'h55555555, 32'h0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      doOp($sformatf("vec%0d", i), 32'h0, tbl[i].srcb, tbl[i].addr, 5'(i + 1), tbl[i].be,
           tbl[i].we, tbl[i].ld, 1'b1, tbl[i].dly, tbl[i].rdata, tbl[i].eAddr, tbl[i].eBe,
           tbl[i].eWd, tbl[i].eRes, tbl[i].eWe);
    end

    // Timeout: 16 BUSY cycles without ack
    resultM = '0; srcbM = '0; addrM = 32'h40; rdM = 5'd9;
    be_memM = 1'b0; we_memM = 1'b0; mux10M = 1'b1; we_regM = 1'b1;
    #1;
    chk("tmo.stallIdle", 32'(stallM), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      chk("tmo.stallBusy", 32'(stallM), 32'd1);
      chk("tmo.errEarly", 32'(bus_err), 32'd0);
      @(posedge clk); #1;
    end
    chk("tmo.stallLast", 32'(stallM), 32'd0);
    chk("tmo.reqLast", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    chk("tmo.busErr", 32'(bus_err), 32'd1);
    chk("tmo.reqDrop", 32'(dmem_req), 32'd0);
    chk("tmo.weW", 32'(we_regW), 32'd0);
    setNop();
    dmem_ack = 1'b1;
    #1;
    chk("tmo.lateAckStall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("tmo.errPulse", 32'(bus_err), 32'd0);
    chk("tmo.lateAckReq", 32'(dmem_req), 32'd0);

    // Reset while a transaction is pending
    addrM = 32'h80; mux10M = 1'b1; we_regM = 1'b1; rdM = 5'd3;
    @(posedge clk); #1;
    chk("rstBusy.reqBefore", 32'(dmem_req), 32'd1);
    setNop();
    rst = 1'b1;
    #1;
    chk("rstBusy.req", 32'(dmem_req), 32'd0);
    chk("rstBusy.addr", dmem_addr, 32'd0);
    chk("rstBusy.be", 32'(dmem_be), 32'd0);
    chk("rstBusy.resW", resultW, 32'd0);
    chk("rstBusy.stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    doOp("postRst", 32'hA5A5, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0,
         32'h0, 4'h0, 32'h0, 32'hA5A5, 1'b1);

`ifdef MEM_MISALIGN_CHK_EN
    resultM = '0; srcbM = '0; addrM = 32'h102; rdM = 5'd4;
    be_memM = 1'b0; we_memM = 1'b0; mux10M = 1'b1; we_regM = 1'b1;
    #1;
    chk("mis.flag", 32'(misalign), 32'd1);
    chk("mis.stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    chk("mis.req", 32'(dmem_req), 32'd0);
    chk("mis.weW", 32'(we_regW), 32'd0);
    setNop();
    #1;
    chk("mis.flagDrop", 32'(misalign), 32'd0);
    @(posedge clk); #1;
`else
    doOp("forceAlign", 32'h0, 32'h0, 32'h106, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h11223344,
         32'h104, 4'hF, 32'h0, 32'h11223344, 1'b1);
`endif

    // Randomized ops against a byte-addressed memory model
    for (int i = 0; i < 64; i++) memB[i] = 8'($urandom);
    for (int n = 0; n < 300; n++) begin
      int kind, a;
      logic byteAcc, we, ld, wer;
      logic [31:0] srcb, res, word, eRes, eWd;
      logic [3:0] eBe;
      logic [4:0] rd;
      kind = int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 63));
      byteAcc = 1'($urandom_range(0, 1));
`ifdef MEM_MISALIGN_CHK_EN
      if (!byteAcc) a = a & ~3;
`endif
      srcb = $urandom; res = $urandom; rd = 5'($urandom); wer = 1'($urandom_range(0, 1));
      we = (kind == 2);
      ld = (kind == 1) || ((kind == 2) && ($urandom_range(0, 1) == 1));
      word = memWord(a);
      eBe = byteAcc ? 4'(1 << (a % 4)) : 4'hF;
      eWd = byteAcc ? {4{srcb[7:0]}} : srcb;
      if (kind == 0)      eRes = res;
      else if (byteAcc)   eRes = {{24{memB[a][7]}}, memB[a]};
      else                eRes = word;
      doOp($sformatf("rnd%0d", n), res, srcb, 32'(a), rd, byteAcc, we, ld, wer,
           int'($urandom_range(0, 4)), word, 32'(a & ~3), eBe, eWd, eRes,
           (kind == 2) ? 1'b0 : wer);
      if (we) begin
        if (byteAcc) memB[a] = srcb[7:0];
        else for (int k = 0; k < 4; k++) memB[(a & ~3) + k] = srcb[8*k +: 8];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
